// File: rtl/tristate_bus_ctrl.sv
// rtl/tristate_bus_ctrl.sv - bidirectional bus port with high-Z turnaround FSM
module tristate_bus_ctrl #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir_req,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             z_clr,
  inout  wire  [WIDTH-1:0] z_state,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             driving,
  output logic             busy,
  output logic [CNT_W-1:0] z_cycles
);

  typedef enum logic [1:0] {S_OFF, S_RECV, S_TURN, S_DRIVE} state_t;

  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [TW-1:0] TLOAD = (TURN_CYCLES > 0) ? TW'(TURN_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] Z_MAX = '1;

  state_t           state_q, state_d;
  logic             tgt_drive_q, tgt_drive_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic [CNT_W-1:0] z_cnt_q, z_cnt_d;

  // The bus release is a decode of the async-reset state, so reset frees it at once.
  assign driving  = (state_q == S_DRIVE);
  assign busy     = (state_q == S_TURN);
  assign z_state  = driving ? tx_q : {WIDTH{1'bz}};
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign z_cycles = z_cnt_q;

  always_comb begin
    state_d     = state_q;
    tgt_drive_d = tgt_drive_q;
    cnt_d       = cnt_q;
    tx_d        = tx_data;
    rx_data_d   = rx_data_q;
    rx_valid_d  = (state_q == S_RECV);
    if (state_q == S_RECV) rx_data_d = z_state;

    if (z_clr)                                     z_cnt_d = '0;
    else if (state_q != S_DRIVE && z_cnt_q != Z_MAX) z_cnt_d = z_cnt_q + 1'b1;
    else                                           z_cnt_d = z_cnt_q;

    unique case (state_q)
      S_OFF: begin
        if (en) state_d = dir_req ? S_DRIVE : S_RECV;
      end
      S_RECV: begin
        if (!en) begin
          state_d = S_OFF;
        end else if (dir_req) begin
          if (TURN_CYCLES == 0) begin
            state_d = S_DRIVE;
          end else begin
            state_d     = S_TURN;
            tgt_drive_d = 1'b1;
            cnt_d       = TLOAD;
          end
        end
      end
      S_TURN: begin
        if (!en) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = tgt_drive_q ? S_DRIVE : S_RECV;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DRIVE: begin
        if (!en) begin
          state_d = S_OFF;
        end else if (!dir_req) begin
          if (TURN_CYCLES == 0) begin
            state_d = S_RECV;
          end else begin
            state_d     = S_TURN;
            tgt_drive_d = 1'b0;
            cnt_d       = TLOAD;
          end
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_OFF;
      tgt_drive_q <= 1'b0;
      cnt_q       <= '0;
      tx_q        <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      z_cnt_q     <= '0;
    end else begin
      state_q     <= state_d;
      tgt_drive_q <= tgt_drive_d;
      cnt_q       <= cnt_d;
      tx_q        <= tx_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      z_cnt_q     <= z_cnt_d;
    end
  end

endmodule
